// File: rtl/systolic_feed_sequencer_pkg.sv
// rtl/systolic_feed_sequencer_pkg.sv - shared types and defaults for the systolic feed path
package systolic_feed_sequencer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LENGTH     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Zero-feed cycles after the last read: skew depth plus array propagation.
  function automatic int drain_cycles(input int length);
    return 2 * length;
  endfunction

endpackage

// File: rtl/systolic_feed_sequencer.sv
// rtl/systolic_feed_sequencer.sv - tile controller streaming operand rows into the skew buffer
module systolic_feed_sequencer
  import systolic_feed_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int LENGTH       = DEFAULT_LENGTH,
  parameter int ADDR_WIDTH   = 10,
  parameter int KLEN_WIDTH   = 9,
  parameter int DRAIN_CYCLES = drain_cycles(LENGTH)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [KLEN_WIDTH-1:0]        k_len,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [DATA_WIDTH*LENGTH-1:0] rd_data,
  output logic [DATA_WIDTH*LENGTH-1:0] buf_din,
  output logic                         acc_clr,
  output logic                         acc_en
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t                 state;
  logic [KLEN_WIDTH-1:0]  k_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [KLEN_WIDTH-1:0]  row_cnt;
  logic [DRAIN_W-1:0]     drain_cnt;
  logic                   rd_vld_q;
  logic [KLEN_WIDTH-1:0]  next_row;

  assign next_row = row_cnt + 1'b1;

  // Tile FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      k_q       <= '0;
      addr_q    <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
    end else begin
      done    <= 1'b0;
      acc_clr <= 1'b0;
      rd_en   <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_CLEAR;
            k_q     <= k_len;
            addr_q  <= base_addr;
            row_cnt <= '0;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          acc_en <= 1'b0;
        end
        ST_CLEAR: begin
          acc_en <= 1'b1;
          if (k_q != '0) begin
            state   <= ST_STREAM;
            rd_en   <= 1'b1;
            rd_addr <= addr_q;
          end else begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_STREAM: begin
          row_cnt <= next_row;
          if (row_cnt == k_q - 1'b1) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else begin
            rd_en   <= 1'b1;
            rd_addr <= addr_q + ADDR_WIDTH'(next_row);
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
            acc_en <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Track SRAM read latency so only returned rows reach the skew buffer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
    end
  end

  // Bubbles are forced to exact zero so the skew flushes cleanly.
  always_comb begin
    buf_din = '0;
    if (rd_vld_q) begin
      buf_din = rd_data;
    end
  end

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// tb/tb_systolic_feed_sequencer.sv - scoreboard bench for systolic_feed_sequencer
module tb_systolic_feed_sequencer;

  localparam int DW  = 8;
  localparam int LEN = 16;
  localparam int AW  = 10;
  localparam int KW  = 9;
  localparam int DR  = 2 * LEN;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic [AW-1:0]     base_addr = '0;
  logic              busy, done, rd_en, acc_clr, acc_en;
  logic [AW-1:0]     rd_addr;
  logic [DW*LEN-1:0] rd_data = '0;
  logic [DW*LEN-1:0] buf_din;

  int vectors = 0;
  int errors  = 0;

  logic [AW-1:0]     exp_addr[$];
  logic [DW*LEN-1:0] exp_data[$];

  always #5 clk = ~clk;

  systolic_feed_sequencer #(
    .DATA_WIDTH(DW), .LENGTH(LEN), .ADDR_WIDTH(AW), .KLEN_WIDTH(KW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len), .base_addr(base_addr),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .buf_din(buf_din), .acc_clr(acc_clr), .acc_en(acc_en)
  );

  function automatic logic [DW*LEN-1:0] pat(input logic [AW-1:0] a);
    logic [DW*LEN-1:0] v;
    for (int i = 0; i < LEN; i++) v[i*DW +: DW] = a[7:0] ^ 8'(i * 16 + 1);
    return v;
  endfunction

  // Operand SRAM model: one-cycle read latency, junk when not reading.
  always @(posedge clk) rd_data <= rd_en ? pat(rd_addr) : {LEN{8'hA5}};

  task automatic launch(input int k, input logic [AW-1:0] base);
    start = 1'b1; k_len = KW'(k); base_addr = base;
  endtask

  // Walks one accepted tile cycle by cycle from CLEAR to done.
  task automatic run_tile(input string tag, input int k, input logic [AW-1:0] base,
                          input int poke_at, input int abort_at,
                          input bit chain, input int ck, input logic [AW-1:0] cb);
    logic [4:0] got, exp;
    logic [AW-1:0] ea;
    logic [DW*LEN-1:0] ed;
    for (int r = 0; r < k; r++) begin
      exp_addr.push_back(base + AW'(r));
      exp_data.push_back(pat(base + AW'(r)));
    end
    for (int c = 1; c <= k + 2 + DR; c++) begin
      @(negedge clk);
      start = 1'b0;
      got = {busy, done, rd_en, acc_clr, acc_en};
      exp = {(c <= k + 1 + DR), (c == k + 2 + DR), (c >= 2 && c <= k + 1),
             (c == 1), (c >= 2 && c <= k + 1 + DR)};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s ctrl c=%0d busy/done/rd_en/clr/en got %b exp %b", tag, c, got, exp);
      end
      if (rd_en === 1'b1 && exp_addr.size() > 0) begin
        ea = exp_addr.pop_front();
        vectors++;
        if (rd_addr !== ea) begin
          errors++;
          $display("FAIL %s rd_addr c=%0d got %h exp %h", tag, c, rd_addr, ea);
        end
      end
      if (c >= 3 && c <= k + 2) begin
        ed = exp_data.size() > 0 ? exp_data.pop_front() : '0;
      end else begin
        ed = '0;
      end
      vectors++;
      if (buf_din !== ed) begin
        errors++;
        $display("FAIL %s buf_din c=%0d got %h exp %h", tag, c, buf_din, ed);
      end
      if (c == abort_at) begin
        rstn = 1'b0;
        return;
      end
      if (c == poke_at) launch(5, 10'h3A0);
      if (c == k + 2 + DR && chain) launch(ck, cb);
    end
    vectors++;
    if (exp_addr.size() != 0 || exp_data.size() != 0) begin
      errors++;
      $display("FAIL %s leftover addr=%0d data=%0d exp 0", tag, exp_addr.size(), exp_data.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) launch(3, 10'h010); else start = 1'b0;
      vectors++;
      if ({busy, done, rd_en, acc_clr, acc_en} !== 5'b0 || buf_din !== '0 || rd_addr !== '0) begin
        errors++;
        $display("FAIL reset i=%0d ctrl %b rd_addr %h buf_din %h exp all zero",
                 i, {busy, done, rd_en, acc_clr, acc_en}, rd_addr, buf_din);
      end
    end
    start = 1'b0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, rd_en, acc_clr, acc_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle got %b exp 00000", {busy, done, rd_en, acc_clr, acc_en});
    end
  endtask

  task automatic test_single(input string tag, input int k, input logic [AW-1:0] base);
    launch(k, base);
    run_tile(tag, k, base, -1, -1, 1'b0, 0, '0);
    @(negedge clk);
    vectors++;
    if ({busy, done, rd_en, acc_clr, acc_en} !== 5'b0) begin
      errors++;
      $display("FAIL %s post_idle got %b exp 00000", tag, {busy, done, rd_en, acc_clr, acc_en});
    end
  endtask

  task automatic test_back_to_back();
    launch(16, 10'h080);
    run_tile("b2b_a", 16, 10'h080, 10, -1, 1'b1, 2, 10'h200);
    run_tile("b2b_b", 2, 10'h200, -1, -1, 1'b0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_tail i=%0d done %b busy %b exp 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    launch(16, 10'h100);
    run_tile("midrst", 16, 10'h100, -1, 9, 1'b0, 0, '0);
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    vectors++;
    if ({busy, done, rd_en, acc_clr, acc_en} !== 5'b0 || buf_din !== '0) begin
      errors++;
      $display("FAIL midrst_after ctrl %b buf_din %h exp zero", {busy, done, rd_en, acc_clr, acc_en}, buf_din);
    end
    rstn = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet i=%0d done %b busy %b rd_en %b exp 0", i, done, busy, rd_en);
      end
    end
    test_single("restart", 16, 10'h100);
  endtask

  initial begin
    test_reset();
    test_single("nominal", 16, 10'h040);
    test_single("wrap", 4, 10'h3FE);
    test_single("zero", 0, 10'h123);
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
